// File: rtl/integration_scheduler_pkg.sv
// Shared types and constants for the integration scheduler and its frame streamer.
package integration_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, INTEGRATE, CLEAR} integ_state_t;
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} strm_state_t;

  // Header word layout: frame count in the LSBs, drop count above it, zero pad on top.
  localparam int FC_LSB   = 0;
  localparam int FC_W     = 16;
  localparam int DROP_LSB = 16;
  localparam int DROP_W   = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/integration_scheduler_if.sv
// Valid/ready word stream from the scheduler to the packetiser/UART path.
interface integration_scheduler_if #(
  parameter int RESOLUTION = 24
);
  logic [RESOLUTION-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/integration_scheduler_frame_streamer.sv
// Holds the snapshot shadow and streams header + payload words with valid/ready.
module frame_streamer
  import integration_scheduler_pkg::*;
#(
  parameter int RESOLUTION = 24,
  parameter int NUM_WORDS  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic [NUM_WORDS*RESOLUTION-1:0] i_payload,
  input  logic [DROP_W-1:0]               i_dropped,
  output logic                            o_busy,
  output logic [FC_W-1:0]                 o_frame_count,
  integration_scheduler_if.master         strm
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  strm_state_t                          r_state;
  logic [NUM_WORDS-1:0][RESOLUTION-1:0] r_shadow;
  logic [IDX_W-1:0]                     r_idx;
  logic [FC_W-1:0]                      r_fc;
  logic                                 r_valid;
  logic                                 r_last;
  logic [RESOLUTION-1:0]                r_data;
  logic [RESOLUTION-1:0]                w_hdr;
  logic [IDX_W-1:0]                     w_idx_nxt;
  logic                                 w_fire;

  assign w_fire    = r_valid & strm.out_ready;
  assign w_idx_nxt = r_idx + 1'b1;

  always_comb begin
    w_hdr = '0;
    w_hdr[FC_LSB +: FC_W]     = r_fc;
    w_hdr[DROP_LSB +: DROP_W] = i_dropped;
  end

  // Data/last are only reloaded on a handshake, so they hold while the sink stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_fc     <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shadow <= i_payload;
            r_state  <= S_HEADER;
            r_valid  <= 1'b1;
            r_data   <= w_hdr;
            r_last   <= 1'b0;
          end
        end
        S_HEADER: begin
          if (w_fire) begin
            r_state <= S_DATA;
            r_idx   <= '0;
            r_data  <= r_shadow[0];
            r_last  <= (NUM_WORDS == 1);
          end
        end
        S_DATA: begin
          if (w_fire) begin
            if (r_idx == LAST_IDX) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_fc    <= r_fc + 1'b1;
            end else begin
              r_idx  <= w_idx_nxt;
              r_data <= r_shadow[w_idx_nxt];
              r_last <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_frame_count = r_fc;
  assign strm.out_valid = r_valid;
  assign strm.out_data  = r_data;
  assign strm.out_last  = r_last;

endmodule

// File: rtl/integration_scheduler.sv
// Integration window sequencer: counts the window, clears the accumulators and hands snapshots to the streamer.
module integration_scheduler
  import integration_scheduler_pkg::*;
#(
  parameter int RESOLUTION = 24,
  parameter int NUM_WORDS  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [CNT_WIDTH-1:0]            integration_cycles,
  input  logic [NUM_WORDS*RESOLUTION-1:0] payload_in,
  output logic                            acc_clear,
  integration_scheduler_if.master         strm,
  output logic                            busy,
  output logic [FC_W-1:0]                 frame_count,
  output logic [DROP_W-1:0]               dropped
);

  integ_state_t         r_state;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_acc_clear;
  logic [DROP_W-1:0]    r_dropped;
  logic [CNT_WIDTH-1:0] w_len_in;
  logic                 w_win_end;
  logic                 w_start;
  logic                 w_busy;

  // A zero-length window would never terminate, so it runs as one cycle.
  assign w_len_in  = (integration_cycles == '0) ? CNT_WIDTH'(1) : integration_cycles;
  assign w_win_end = (r_state == INTEGRATE) && enable && (r_cnt == r_len - 1'b1);
  assign w_start   = w_win_end && !w_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_acc_clear <= 1'b1;
      r_dropped   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_acc_clear <= 1'b1;
          if (enable) begin
            r_len       <= w_len_in;
            r_cnt       <= '0;
            r_state     <= INTEGRATE;
            r_acc_clear <= 1'b0;
          end
        end
        INTEGRATE: begin
          r_cnt <= r_cnt + 1'b1;
          if (!enable) begin
            r_state     <= IDLE;
            r_acc_clear <= 1'b1;
          end else if (w_win_end) begin
            r_state     <= CLEAR;
            r_acc_clear <= 1'b1;
            if (w_busy) r_dropped <= sat_inc(r_dropped);
          end
        end
        CLEAR: begin
          if (enable) begin
            r_len       <= w_len_in;
            r_cnt       <= '0;
            r_state     <= INTEGRATE;
            r_acc_clear <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc_clear <= 1'b1;
        end
      endcase
    end
  end

  frame_streamer #(
    .RESOLUTION (RESOLUTION),
    .NUM_WORDS  (NUM_WORDS)
  ) u_streamer (
    .clk           (clk),
    .reset         (reset),
    .i_start       (w_start),
    .i_payload     (payload_in),
    .i_dropped     (r_dropped),
    .o_busy        (w_busy),
    .o_frame_count (frame_count),
    .strm          (strm)
  );

  assign acc_clear = r_acc_clear;
  assign busy      = w_busy;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_integration_scheduler.sv
// Directed bench: cycle table for a nominal window plus hand-written stall/drop/reset sequences.
module tb_integration_scheduler;

  localparam int RES = 24;
  localparam int NW  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [31:0]       ic;
  logic [NW*RES-1:0] payload;
  logic              acc_clear;
  logic              busy;
  logic [15:0]       fc;
  logic [7:0]        dropped;

  integration_scheduler_if #(.RESOLUTION(RES)) sif();

  integration_scheduler #(
    .RESOLUTION (RES),
    .NUM_WORDS  (NW),
    .CNT_WIDTH  (32)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .integration_cycles (ic),
    .payload_in         (payload),
    .acc_clear          (acc_clear),
    .strm               (sif),
    .busy               (busy),
    .frame_count        (fc),
    .dropped            (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ac;
    logic        vld;
    logic [23:0] data;
    logic        last;
    logic        bsy;
    logic [15:0] fc;
  } vec_t;

  vec_t tv [23];
  int total = 0;
  int bad   = 0;

  localparam logic [NW*RES-1:0] P1 = {24'h000044, 24'h000033, 24'h000022, 24'h000011};
  localparam logic [NW*RES-1:0] P2 = {24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    sif.out_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic start(input logic [31:0] len, input logic rdy);
    ic = len;
    sif.out_ready = rdy;
    enable = 1'b1;
    reset = 1'b1;
  endtask

  initial begin
    bit seen;
    bit found;
    reset = 1'b0;
    enable = 1'b0;
    ic = 32'd10;
    payload = P1;
    sif.out_ready = 1'b0;

    // expected state after each of edges 1..22 of a 10-cycle window, ready held high
    for (int i = 1; i <= 22; i++) begin
      tv[i].ac   = (i == 11 || i == 22);
      tv[i].vld  = 1'b0;
      tv[i].data = 24'h0;
      tv[i].last = 1'b0;
      tv[i].bsy  = 1'b0;
      tv[i].fc   = (i >= 16) ? 16'd1 : 16'd0;
    end
    for (int i = 11; i <= 15; i++) begin
      tv[i].vld = 1'b1;
      tv[i].bsy = 1'b1;
    end
    tv[12].data = 24'h11;
    tv[13].data = 24'h22;
    tv[14].data = 24'h33;
    tv[15].data = 24'h44;
    tv[15].last = 1'b1;
    tv[22].vld  = 1'b1;
    tv[22].bsy  = 1'b1;
    tv[22].data = 24'h000001;

    // reset state
    do_reset();
    chk("rst_acc_clear", acc_clear, 1);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_last", sif.out_last, 0);
    chk("rst_data", sif.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", fc, 0);
    chk("rst_dropped", dropped, 0);

    // 1: nominal window and frame
    start(32'd10, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      tick();
      chk($sformatf("t1_e%0d_acc_clear", i), acc_clear, tv[i].ac);
      chk($sformatf("t1_e%0d_valid", i), sif.out_valid, tv[i].vld);
      chk($sformatf("t1_e%0d_last", i), sif.out_last, tv[i].last);
      chk($sformatf("t1_e%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("t1_e%0d_fc", i), fc, tv[i].fc);
      if (tv[i].vld) chk($sformatf("t1_e%0d_data", i), sif.out_data, tv[i].data);
    end

    // 2: sink stalls on the header across two window ends
    do_reset();
    payload = P1;
    start(32'd10, 1'b0);
    repeat (11) tick();
    chk("t2_hdr_valid", sif.out_valid, 1);
    chk("t2_hdr_data", sif.out_data, 0);
    payload = P2;
    for (int k = 12; k <= 34; k++) begin
      tick();
      chk($sformatf("t2_e%0d_hold_valid", k), sif.out_valid, 1);
      chk($sformatf("t2_e%0d_hold_data", k), sif.out_data, 0);
      chk($sformatf("t2_e%0d_hold_last", k), sif.out_last, 0);
      if (k == 22) chk("t2_dropped1", dropped, 1);
      if (k == 33) chk("t2_dropped2", dropped, 2);
    end
    sif.out_ready = 1'b1;
    for (int w = 0; w < NW; w++) begin
      tick();
      chk($sformatf("t2_word%0d", w), sif.out_data, 24'h11 * (w + 1));
      chk($sformatf("t2_last%0d", w), sif.out_last, (w == NW - 1));
    end
    tick();
    chk("t2_idle_busy", busy, 0);
    chk("t2_fc", fc, 1);
    repeat (5) tick();
    chk("t2_hdr2_valid", sif.out_valid, 1);
    chk("t2_hdr2_data", sif.out_data, 24'h020001);

    // 3: zero length runs as one cycle; snapshots drop while streaming
    do_reset();
    payload = P1;
    start(32'd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t3_e%0d_acc_clear", i), acc_clear, (i % 2 == 0));
      if (i == 2) chk("t3_hdr1", sif.out_data, 0);
      if (i == 4) chk("t3_dropped1", dropped, 1);
    end
    chk("t3_dropped2", dropped, 2);
    chk("t3_hdr2_valid", sif.out_valid, 1);
    chk("t3_hdr2_data", sif.out_data, 24'h020001);

    // 4: enable falls mid-window
    do_reset();
    start(32'd10, 1'b1);
    repeat (6) tick();
    chk("t4_acc_clear_cnt5", acc_clear, 0);
    enable = 1'b0;
    tick();
    chk("t4_acc_clear_idle", acc_clear, 1);
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (sif.out_valid || !acc_clear) seen = 1'b1;
    end
    chk("t4_no_activity", seen, 0);
    chk("t4_dropped", dropped, 0);
    chk("t4_fc", fc, 0);

    // 5: reset in the middle of the second frame's payload
    do_reset();
    payload = P1;
    start(32'd10, 1'b1);
    repeat (25) tick();
    chk("t5_pre_fc", fc, 1);
    chk("t5_pre_data_idx2", sif.out_data, 24'h33);
    reset = 1'b0;
    tick();
    chk("t5_valid", sif.out_valid, 0);
    chk("t5_last", sif.out_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_acc_clear", acc_clear, 1);
    chk("t5_fc", fc, 0);
    chk("t5_dropped", dropped, 0);

    // 6: drop counter saturation
    do_reset();
    start(32'd1, 1'b0);
    repeat (620) tick();
    chk("t6_dropped_sat", dropped, 8'hFF);
    chk("t6_hdr_held", sif.out_data, 0);
    sif.out_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      tick();
      if (sif.out_valid && fc == 16'd1) found = 1'b1;
    end
    chk("t6_wait_hdr2", found, 1);
    chk("t6_hdr2_data", sif.out_data, 24'hFF0001);
    chk("t6_dropped_still_sat", dropped, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
